// File: rtl/mult_1.sv
// Unsigned DW x DW multiplier built from an explicit partial-product array, full 2*DW-bit result.
// Latency: one cycle; the product of operands present at rising edge N appears after edge N.
// Backpressure: none; a new operand pair is accepted on every edge and the output reloads every edge.
module mult_1 #(
    parameter int DW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   i0,
    input  logic [DW-1:0]   i1,
    output logic [2*DW-1:0] output_value
);

    localparam int PW = 2 * DW;

    // Row k is i0 gated by multiplier bit k, zero-extended to full width and
    // shifted into its weight position. Each generate stage adds its row to the
    // running sum of the stages below it, so the last stage holds the product.
    // Zero extension to 2*DW bits before summing means no carry is ever lost.
    genvar k;
    generate
        for (k = 0; k < DW; k++) begin : g_row
            logic [PW-1:0] row;
            logic [PW-1:0] sum;

            assign row = {{DW{1'b0}}, (i0 & {DW{i1[k]}})} << k;

            if (k == 0) begin : g_first
                assign sum = row;
            end else begin : g_add
                assign sum = g_row[k-1].sum + row;
            end
        end
    endgenerate

    // Output register: cleared asynchronously by reset, otherwise captures the array result every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_value <= '0;
        end else begin
            output_value <= g_row[DW-1].sum;
        end
    end

endmodule

// File: tb/tb_mult_1.sv
// Scoreboard bench for mult_1 at DW=1, DW=8 and DW=32 running side by side.
// The driver changes operands on the falling edge and queues the expected product;
// the monitor pops one entry per rising edge and compares all three outputs.
module tb_mult_1;

    logic        clk;
    logic        rst_n;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic [1:0]  y1;
    logic [15:0] y8;
    logic [63:0] y32;

    typedef struct {
        logic [1:0]  e1;
        logic [15:0] e8;
        logic [63:0] e32;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int n_tests = 0;
    int n_fail  = 0;

    mult_1 #(.DW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i0(a1), .i1(b1), .output_value(y1)
    );
    mult_1 #(.DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i0(a8), .i1(b8), .output_value(y8)
    );
    mult_1 #(.DW(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .i0(a32), .i1(b32), .output_value(y32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer multiplication, or zero while reset is held.
    function automatic exp_t model(input logic rst_v, input logic [0:0] p1, input logic [0:0] q1,
                                   input logic [7:0] p8, input logic [7:0] q8,
                                   input logic [31:0] p32, input logic [31:0] q32);
        exp_t e;
        longint unsigned w;
        if (!rst_v) begin
            e.e1 = '0; e.e8 = '0; e.e32 = '0;
        end else begin
            e.e1  = 2'(int'(p1) * int'(q1));
            e.e8  = 16'(int'(p8) * int'(q8));
            w     = longint'(p32) * longint'(q32);
            e.e32 = 64'(w);
        end
        return e;
    endfunction

    // One cycle of stimulus: drive on the falling edge, queue what the next rising edge must produce.
    task automatic step(input logic rst_v, input logic [0:0] p1, input logic [0:0] q1,
                        input logic [7:0] p8, input logic [7:0] q8,
                        input logic [31:0] p32, input logic [31:0] q32);
        @(negedge clk);
        rst_n = rst_v;
        a1 = p1;  b1 = q1;
        a8 = p8;  b8 = q8;
        a32 = p32; b32 = q32;
        sb.push_back(model(rst_v, p1, q1, p8, q8, p32, q32));
    endtask

    // Monitor: the output is presented every cycle, so one queued entry is consumed per rising edge.
    initial begin
        cur.e1 = '0; cur.e8 = '0; cur.e32 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("prod_dw1",  64'(y1),  64'(cur.e1));
                check("prod_dw8",  64'(y8),  64'(cur.e8));
                check("prod_dw32", y32,      cur.e32);
            end
        end
    end

    initial begin
        logic [7:0]  r8a, r8b;
        logic [31:0] r32a, r32b;
        logic [0:0]  r1a, r1b;
        int          budget;

        rst_n = 1'b0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
        #1;
        check("reset_dw1",  64'(y1),  64'h0);
        check("reset_dw8",  64'(y8),  64'h0);
        check("reset_dw32", y32,      64'h0);

        // Release and directed patterns, including the all-ones boundary at every width.
        step(1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   32'd0,          32'd0);
        step(1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        step(1'b1, 1'b1, 1'b0, 8'd13,  8'd11,  32'h8000_0000,  32'd2);
        step(1'b1, 1'b1, 1'b1, 8'd0,   8'd200, 32'd0,          32'hDEAD_BEEF);
        // Back-to-back stream with no bubbles.
        step(1'b1, 1'b1, 1'b1, 8'd3,   8'd4,   32'd3,          32'd4);
        step(1'b1, 1'b0, 1'b1, 8'd10,  8'd10,  32'd65536,      32'd65536);
        step(1'b1, 1'b1, 1'b1, 8'd255, 8'd1,   32'hFFFF_FFFF,  32'd1);
        step(1'b1, 1'b1, 1'b1, 8'd13,  8'd11,  32'd13,         32'd11);

        // The output now shows 143; pull reset between edges and expect an immediate clear.
        @(negedge clk);
        check("pre_reset_dw8", 64'(y8), 64'd143);
        rst_n = 1'b0;
        #1;
        check("async_clr_dw1",  64'(y1),  64'h0);
        check("async_clr_dw8",  64'(y8),  64'h0);
        check("async_clr_dw32", y32,      64'h0);
        a1 = 1'b1; b1 = 1'b1; a8 = 8'd7; b8 = 8'd9; a32 = 32'd7; b32 = 32'd9;
        sb.push_back(model(1'b0, a1, b1, a8, b8, a32, b32));
        step(1'b0, 1'b1, 1'b1, 8'd7, 8'd9, 32'd7, 32'd9);
        step(1'b1, 1'b1, 1'b1, 8'd7, 8'd9, 32'd7, 32'd9);

        // Operands wiggled mid-cycle must not reach the output before the next edge.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; a8 = 8'd99; b8 = 8'd77; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
        #2;
        check("hold_dw1",  64'(y1),  64'(cur.e1));
        check("hold_dw8",  64'(y8),  64'(cur.e8));
        check("hold_dw32", y32,      cur.e32);
        a1 = 1'b0; b1 = 1'b1; a8 = 8'd5; b8 = 8'd6; a32 = 32'd100000; b32 = 32'd300000;
        sb.push_back(model(1'b1, a1, b1, a8, b8, a32, b32));

        // Random traffic, biased toward zero and all-ones operands.
        for (int n = 0; n < 300; n++) begin
            r1a = 1'($urandom); r1b = 1'($urandom);
            r8a = 8'($urandom); r8b = 8'($urandom);
            r32a = $urandom; r32b = $urandom;
            case ($urandom_range(0, 7))
                0: begin r8a = 8'hFF; r32a = 32'hFFFF_FFFF; end
                1: begin r8b = 8'hFF; r32b = 32'hFFFF_FFFF; end
                2: begin r8a = 8'h00; r32b = 32'h0; end
                default: ;
            endcase
            step(1'b1, r1a, r1b, r8a, r8b, r32a, r32b);
        end

        // Let the monitor drain the scoreboard, bounded.
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
